// File: rtl/uart_rx_controller_pkg.sv
// ============================================================================
// Module      : uart_rx_controller_pkg
// Description : Shared state encoding and defaults for the UART RX controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_controller_pkg;

    localparam int c_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        RXC_OFF   = 2'd0,
        RXC_ARMED = 2'd1,
        RXC_FULL  = 2'd2,
        RXC_FLUSH = 2'd3
    } rxc_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_controller_if.sv
// ============================================================================
// Module      : uart_rx_controller_if
// Description : Frame handshake between the RX controller and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_controller_if #(
    parameter int N = uart_rx_controller_pkg::c_DEFAULT_N
);
    logic [N-1:0] out_data;
    logic         out_par_err;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_par_err,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_par_err,
        input  out_valid,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous show-ahead FIFO with a registered head output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_flush,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_head,
    output logic                          o_valid,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop;
    logic             w_push;
    logic [c_AW-1:0]  w_rd_ptr_nxt;
    logic [c_CW-1:0]  w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_pop        = i_pop && (r_count != '0);
    assign w_push       = i_push && ((r_count != c_DEPTH) || w_pop);
    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + c_AW'(1) : r_rd_ptr;
    assign w_count_nxt  = r_count + c_CW'(w_push) - c_CW'(w_pop);

    // The incoming word becomes the head only when nothing older survives this edge.
    assign w_head_nxt = (w_push && ((r_count - c_CW'(w_pop)) == '0)) ? i_wdata
                                                                     : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_head   <= (w_count_nxt != '0) ? w_head_nxt : '0;
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_rx_controller.sv
// ============================================================================
// Module      : uart_rx_controller
// Description : Enables the UART receiver, queues frames and tracks errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic                   uart_clock,
    input  wire logic                   rst,
    input  wire logic                   ctrl_enable,
    input  wire logic                   ctrl_drop_bad,
    input  wire logic                   ctrl_flush,
    input  wire logic                   rx_done,
    input  wire logic [N-1:0]           rx_data,
    input  wire logic                   rx_par,
    output logic                        rx_enable,
    output logic                        rx_clear,
    uart_rx_controller_if.master        out_if,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic [CNT_W-1:0]            overrun_cnt,
    output logic [CNT_W-1:0]            parity_err_cnt,
    output logic                        busy
);

    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    rxc_state_t       r_state;
    rxc_state_t       w_state_nxt;
    logic             w_rx_enable;
    logic             w_rx_clear;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_valid;
    logic [N:0]       w_head;
    logic [c_CW-1:0]  w_count;
    logic [c_CW-1:0]  w_count_nxt;

    logic             w_frame_in;
    logic             w_want_push;
    logic             w_pop;
    logic             w_push;
    logic             w_overrun;
    logic             w_par_hit;

    logic [CNT_W-1:0] r_overrun_cnt;
    logic [CNT_W-1:0] r_parity_err_cnt;

    assign w_rx_enable = (r_state == RXC_ARMED) || (r_state == RXC_FULL);

    // Parity errors count on every enabled reception, even if the frame is dropped.
    assign w_frame_in  = rx_done && w_rx_enable;
    assign w_par_hit   = w_frame_in && rx_par;
    assign w_want_push = w_frame_in && !(rx_par && ctrl_drop_bad) && !ctrl_flush;
    assign w_pop       = out_if.out_ready && !w_fifo_empty && !ctrl_flush;
    assign w_push      = w_want_push && (!w_fifo_full || w_pop);
    assign w_overrun   = w_want_push && w_fifo_full && !w_pop;
    assign w_count_nxt = ctrl_flush ? '0 : w_count + c_CW'(w_push) - c_CW'(w_pop);

    uart_rx_fifo #(
        .WIDTH (N + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (uart_clock),
        .rst_n   (rst),
        .i_flush (ctrl_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({rx_par, rx_data}),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    always_ff @(posedge uart_clock or negedge rst) begin
        if (!rst) begin
            r_state <= RXC_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rx_clear  = 1'b0;
        if (ctrl_flush) begin
            w_state_nxt = RXC_FLUSH;
        end else begin
            case (r_state)
                RXC_OFF: begin
                    if (ctrl_enable) begin
                        w_state_nxt = RXC_ARMED;
                        w_rx_clear  = 1'b1;
                    end
                end
                RXC_ARMED: begin
                    if (!ctrl_enable) begin
                        w_state_nxt = RXC_OFF;
                        w_rx_clear  = 1'b1;
                    end else if (w_count_nxt == c_DEPTH) begin
                        w_state_nxt = RXC_FULL;
                    end
                end
                RXC_FULL: begin
                    if (!ctrl_enable) begin
                        w_state_nxt = RXC_OFF;
                        w_rx_clear  = 1'b1;
                    end else if (w_count_nxt != c_DEPTH) begin
                        w_state_nxt = RXC_ARMED;
                    end
                end
                RXC_FLUSH: begin
                    w_state_nxt = ctrl_enable ? RXC_ARMED : RXC_OFF;
                end
                default: begin
                    w_state_nxt = RXC_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge uart_clock or negedge rst) begin
        if (!rst) begin
            r_overrun_cnt    <= '0;
            r_parity_err_cnt <= '0;
        end else begin
            if (w_overrun && (r_overrun_cnt != '1)) begin
                r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
            end
            if (w_par_hit && (r_parity_err_cnt != '1)) begin
                r_parity_err_cnt <= r_parity_err_cnt + CNT_W'(1);
            end
        end
    end

    // Reset holds the FSM in OFF; masking keeps that from looking like an enable edge.
    assign rx_clear           = w_rx_clear && rst;
    assign rx_enable          = w_rx_enable;
    assign busy               = (r_state != RXC_OFF);
    assign fifo_count         = w_count;
    assign overrun_cnt        = r_overrun_cnt;
    assign parity_err_cnt     = r_parity_err_cnt;
    assign out_if.out_data    = w_head[N-1:0];
    assign out_if.out_par_err = w_head[N];
    assign out_if.out_valid   = w_fifo_valid;

endmodule

`default_nettype wire
